generador_notas: RTL and testbench
==================================

# generador_notas

Parametrised tone generator for the music-box datapath. It debounces N key inputs and selects the lowest-index pressed key. It then produces a square wave whose half-period comes from a per-key table, optionally shifted up by 0–3 octaves. Frequency changes and note start/stop happen only on half-period boundaries, so `clk_out` never carries a runt pulse. It drives the speaker/output stage directly.

## Interface
- `N_TECLAS`, 7: number of key inputs (≥1).
- `CNT_W`, 16: width of half-period counter and table entries.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable clocks required to accept a key change (≥1).
- `MITAD_PERIODOS`, {12658,14205,15954,17908,18968,21295,23901} (MSB→LSB): packed N_TECLAS×CNT_W half-periods in clocks, for 50 MHz DO..SI. Entry i is at bits [i*CNT_W +: CNT_W]; entry 0 is DO = 23901.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `teclas`  in  N_TECLAS  raw asynchronous key levels, 1 = pressed.
- `octava`  in  2  octave shift 0–3; the effective half-period is the table entry >> octava.
- `clk_out`  out  1  square-wave tone output.
- `activo`  out  1  high while the FSM is in SONANDO.
- `nota`  out  max(1,$clog2(N_TECLAS))  index of the sounding key; valid while `activo`.

## Operation
- Synchronous reset (highest priority):
  - clears both synchronizer stages, the debounced vector, all debounce counters, the half-period counter and the held half-period;
  - sets state REPOSO;
  - drives `clk_out`=0, `activo`=0, `nota`=0.
  - Reset asserted mid-note silences the output on the next edge.
- Input path, per key:
  - 2-FF synchronizer, then a debounce counter.
  - The counter increments while the synced bit ≠ the debounced bit and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the bits still unequal: debounced bit ← synced bit, counter ← 0.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Selection: combinational priority over the debounced vector; the lowest set index wins. "Pressed" means any debounced bit is set.
- Effective half-period H = entry[sel] >> octava. If the result is 0, H = 1.
- FSM states REPOSO and SONANDO:
  - REPOSO: `clk_out`=0, counter=0. If pressed, on the next edge:
    - go to SONANDO, `clk_out`←1, counter←0;
    - latch H and `nota`←sel.
  - SONANDO: the counter increments each clock. At terminal count (counter = Hheld-1):
    - counter←0 and `clk_out` toggles;
    - if pressed: re-latch H and `nota` from the current sel/`octava` and stay in SONANDO;
    - if not pressed and `clk_out` was 1: `clk_out`←0, go to REPOSO;
    - if not pressed and `clk_out` was 0: `clk_out` stays 0, go to REPOSO.
  - Between terminal counts, changes to `teclas` or `octava` have no effect on `clk_out`, `nota` or Hheld.
- Every high and low level of `clk_out` lasts exactly Hheld clocks. The sounding waveform has a 50% duty cycle.

## Timing
- Pin to debounced bit: nominal 2 + DEBOUNCE_CYCLES clocks.
- Debounced press while in REPOSO → `clk_out` and `activo` rise on the next clock edge.
- Key or `octava` change while sounding → takes effect at the next half-period boundary, at most Hheld clocks later.
- Release while sounding:
  - `clk_out` returns to 0 at the end of the current high half;
  - if the current half is low, the low half completes first;
  - `activo` falls on the same edge.
- Release and a new press debounced in the same cycle: selection sees the new key, so the note changes without a gap.
- Counter wrap: reaching Hheld-1 always returns the counter to 0. With H=1, `clk_out` toggles every clock.

## Test plan
Parameters for tests 1–5: N_TECLAS=3, CNT_W=8, DEBOUNCE_CYCLES=4, MITAD_PERIODOS={8'd12, 8'd6, 8'd4}.

1. Reset, then hold `teclas`=3'b000 for 50 clocks → `clk_out`=0, `activo`=0 and `nota`=0 throughout.
2. `teclas`=3'b001, `octava`=0 → `activo` rises about 7 clocks later; `clk_out` alternates 4 high / 4 low; `nota`=0.
3. Hold key 0, then add key 1 (3'b011) → no change (key 0 has priority). Then drop key 0 (3'b010) → after debounce, the next boundary switches to 6-cycle halves and `nota`=1.
4. Key 2 with `octava`=2 → halves are 3 clocks. Change to `octava`=3 mid-half → the current half stays 3 clocks, then halves are 1 clock.
5. Apply a 3-clock pulse on `teclas`[0] → no debounced press; output stays silent. Press key 0, release mid-high half → the high half completes (4 clocks total), then `clk_out`=0 and `activo`=0.
6. Assert `reset` mid-note with default parameters → all outputs 0 on the next edge. Deassert with key 0 held → the tone restarts with 23901-clock halves.

Source files
------------

// File: rtl/generador_notas.sv
// Square-wave tone generator: debounced key bank, lowest-index priority select,
// octave shift, and note changes/stops only on half-period boundaries.
module generador_notas #(
  parameter int N_TECLAS        = 7,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter logic [N_TECLAS*CNT_W-1:0] MITAD_PERIODOS = {
    16'd12658, 16'd14205, 16'd15954, 16'd17908, 16'd18968, 16'd21295, 16'd23901}
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [N_TECLAS-1:0]                            teclas,
  input  logic [1:0]                                     octava,
  output logic                                           clk_out,
  output logic                                           activo,
  output logic [((N_TECLAS > 1) ? $clog2(N_TECLAS) : 1)-1:0] nota
);

  localparam int NOTA_W = (N_TECLAS > 1) ? $clog2(N_TECLAS) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_FIN = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {REPOSO, SONANDO} estado_t;

  logic [N_TECLAS-1:0] sync1, sync2, deb;
  logic [DEB_W-1:0]    deb_cnt [N_TECLAS];

  logic                pressed;
  logic [NOTA_W-1:0]   sel;
  logic [CNT_W-1:0]    entrada, h_desp, h_nuevo;

  estado_t             estado, estado_sig;
  logic [CNT_W-1:0]    cnt, cnt_sig, h_held, h_sig;
  logic                clk_sig;
  logic [NOTA_W-1:0]   nota_sig;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= teclas;
      sync2 <= sync1;
    end
  end

  // A key change is only accepted after DEBOUNCE_CYCLES consecutive clocks of disagreement.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= '0;
      for (int i = 0; i < N_TECLAS; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_TECLAS; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_FIN) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    sel     = '0;
    pressed = |deb;
    for (int i = N_TECLAS - 1; i >= 0; i--) begin
      if (deb[i]) sel = NOTA_W'(i);
    end
    entrada = MITAD_PERIODOS[int'(sel)*CNT_W +: CNT_W];
    h_desp  = entrada >> octava;
    h_nuevo = (h_desp == '0) ? CNT_W'(1) : h_desp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado  <= REPOSO;
      cnt     <= '0;
      h_held  <= '0;
      clk_out <= 1'b0;
      nota    <= '0;
    end else begin
      estado  <= estado_sig;
      cnt     <= cnt_sig;
      h_held  <= h_sig;
      clk_out <= clk_sig;
      nota    <= nota_sig;
    end
  end

  // Key/octave changes are only sampled at terminal count so every half lasts h_held clocks.
  always_comb begin
    estado_sig = estado;
    cnt_sig    = cnt;
    h_sig      = h_held;
    clk_sig    = clk_out;
    nota_sig   = nota;
    case (estado)
      REPOSO: begin
        clk_sig = 1'b0;
        cnt_sig = '0;
        if (pressed) begin
          estado_sig = SONANDO;
          clk_sig    = 1'b1;
          h_sig      = h_nuevo;
          nota_sig   = sel;
        end
      end
      SONANDO: begin
        if (cnt == h_held - CNT_W'(1)) begin
          cnt_sig = '0;
          if (pressed) begin
            clk_sig  = ~clk_out;
            h_sig    = h_nuevo;
            nota_sig = sel;
          end else begin
            clk_sig    = 1'b0;
            estado_sig = REPOSO;
          end
        end else begin
          cnt_sig = cnt + CNT_W'(1);
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  assign activo = (estado == SONANDO);

endmodule

// File: tb/tb_generador_notas.sv
// Bench for generador_notas: directed steps plus random key traffic on a small
// instance checked every clock against a per-key/half-length reference model.
module tb_generador_notas;

  localparam int N   = 3;
  localparam int W   = 8;
  localparam int DEB = 4;
  localparam logic [N*W-1:0] TABLA = {8'd12, 8'd6, 8'd4};
  localparam int MITADES [N] = '{4, 6, 12};

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] teclas;
  logic [1:0] octava;
  logic       clk_out, activo;
  logic [1:0] nota;

  logic       reset_b;
  logic [6:0] teclas_b;
  logic [1:0] octava_b;
  logic       clk_out_b, activo_b;
  logic [2:0] nota_b;

  int checks   = 0;
  int failures = 0;

  generador_notas #(
    .N_TECLAS(N), .CNT_W(W), .DEBOUNCE_CYCLES(DEB), .MITAD_PERIODOS(TABLA)
  ) dut (
    .clk(clk), .reset(reset), .teclas(teclas), .octava(octava),
    .clk_out(clk_out), .activo(activo), .nota(nota)
  );

  generador_notas #(
    .N_TECLAS(7), .CNT_W(16), .DEBOUNCE_CYCLES(DEB)
  ) dut_b (
    .clk(clk), .reset(reset_b), .teclas(teclas_b), .octava(octava_b),
    .clk_out(clk_out_b), .activo(activo_b), .nota(nota_b)
  );

  always #5 clk = ~clk;

  // Reference: keys are pin histories with a mismatch run length; tone is
  // "clocks left in the current half" plus level.
  logic [2:0] m_s1, m_s2, m_deb;
  int         m_run [N];
  logic       m_act, m_lvl;
  int         m_nota, m_left;

  function automatic int mitad(input int k, input int o);
    int h;
    h = MITADES[k] >> o;
    return (h == 0) ? 1 : h;
  endfunction

  task automatic modelStep();
    bit pr;
    int s;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_act = 0; m_lvl = 0; m_nota = 0; m_left = 0;
      return;
    end
    pr = |m_deb;
    s  = 0;
    for (int i = N - 1; i >= 0; i--) if (m_deb[i]) s = i;
    if (!m_act) begin
      if (pr) begin
        m_act = 1; m_lvl = 1; m_left = mitad(s, int'(octava)); m_nota = s;
      end
    end else if (m_left > 1) begin
      m_left--;
    end else if (pr) begin
      m_lvl = ~m_lvl; m_left = mitad(s, int'(octava)); m_nota = s;
    end else begin
      m_act = 0; m_lvl = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] >= DEB) begin
          m_deb[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = teclas;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("clk_out", 32'(clk_out), 32'(m_lvl));
    checkOutput("activo", 32'(activo), 32'(m_act));
    if (m_act) checkOutput("nota", 32'(nota), 32'(m_nota));
  endtask

  task automatic applyStimulus(input logic [2:0] k, input logic [1:0] o, input int ciclos);
    teclas = k;
    octava = o;
    for (int i = 0; i < ciclos; i++) tick();
  endtask

  task automatic waitActivo(input logic want, input int bound, output int n);
    n = 0;
    while (activo !== want && n < bound) begin tick(); n++; end
  endtask

  task automatic waitActivoB(input logic want, input int bound, output int n);
    n = 0;
    while (activo_b !== want && n < bound) begin tick(); n++; end
  endtask

  task automatic waitNota(input logic [1:0] want, input int bound, output int n);
    n = 0;
    while (nota !== want && n < bound) begin tick(); n++; end
  endtask

  task automatic measureHalf(input bit big, input int bound, output int n);
    logic lvl;
    lvl = big ? clk_out_b : clk_out;
    n = 1;
    while (n < bound) begin
      tick();
      if ((big ? clk_out_b : clk_out) !== lvl) break;
      n++;
    end
  endtask

  initial begin
    int n, altos;
    reset = 1'b1; teclas = '0; octava = '0;
    reset_b = 1'b1; teclas_b = '0; octava_b = '0;
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_act = 0; m_lvl = 0; m_nota = 0; m_left = 0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("rst_clk_out", 32'(clk_out), 32'd0);
    checkOutput("rst_activo", 32'(activo), 32'd0);
    checkOutput("rst_nota", 32'(nota), 32'd0);
    checkOutput("rst_b_clk_out", 32'(clk_out_b), 32'd0);
    reset = 1'b0;
    reset_b = 1'b0;

    $display("[TB] idle with no keys");
    altos = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(3'b000, 2'd0, 1);
      if (clk_out !== 1'b0 || activo !== 1'b0 || nota !== 2'd0) altos++;
    end
    checkOutput("t1_silent", 32'(altos), 32'd0);

    $display("[TB] key 0 tone");
    teclas = 3'b001;
    waitActivo(1'b1, 20, n);
    checkOutput("t2_press_latency", 32'(n), 32'd7);
    measureHalf(0, 50, n);
    checkOutput("t2_high_half", 32'(n), 32'd4);
    measureHalf(0, 50, n);
    checkOutput("t2_low_half", 32'(n), 32'd4);
    checkOutput("t2_nota", 32'(nota), 32'd0);

    $display("[TB] priority and key change");
    applyStimulus(3'b011, 2'd0, 20);
    checkOutput("t3_priority", 32'(nota), 32'd0);
    teclas = 3'b010;
    waitNota(2'd1, 40, n);
    checkOutput("t3_switch", 32'(nota), 32'd1);
    measureHalf(0, 50, n);
    checkOutput("t3_half6", 32'(n), 32'd6);

    $display("[TB] octave shift");
    teclas = 3'b100;
    octava = 2'd2;
    waitNota(2'd2, 40, n);
    checkOutput("t4_nota2", 32'(nota), 32'd2);
    measureHalf(0, 50, n);
    checkOutput("t4_half3", 32'(n), 32'd3);
    octava = 2'd3;
    measureHalf(0, 50, n);
    checkOutput("t4_half_held", 32'(n), 32'd3);
    measureHalf(0, 50, n);
    checkOutput("t4_half1_a", 32'(n), 32'd1);
    measureHalf(0, 50, n);
    checkOutput("t4_half1_b", 32'(n), 32'd1);

    $display("[TB] glitch and release");
    applyStimulus(3'b000, 2'd0, 0);
    waitActivo(1'b0, 60, n);
    checkOutput("t5_stop", 32'(activo), 32'd0);
    applyStimulus(3'b000, 2'd0, 10);
    applyStimulus(3'b001, 2'd0, 3);
    applyStimulus(3'b000, 2'd0, 15);
    checkOutput("t5_glitch_activo", 32'(activo), 32'd0);
    checkOutput("t5_glitch_clk", 32'(clk_out), 32'd0);
    teclas = 3'b001;
    waitActivo(1'b1, 20, n);
    checkOutput("t5_press_a", 32'(n), 32'd7);
    teclas = 3'b000;
    waitActivo(1'b0, 40, n);
    checkOutput("t5_release_low", 32'(n), 32'd8);
    applyStimulus(3'b000, 2'd0, 10);
    teclas = 3'b001;
    waitActivo(1'b1, 20, n);
    checkOutput("t5_press_b", 32'(n), 32'd7);
    applyStimulus(3'b001, 2'd0, 3);
    teclas = 3'b000;
    waitActivo(1'b0, 40, n);
    checkOutput("t5_release_high", 32'(n), 32'd9);
    checkOutput("t5_release_clk", 32'(clk_out), 32'd0);

    $display("[TB] random traffic");
    for (int it = 0; it < 250; it++) begin
      teclas = 3'($urandom);
      if ($urandom_range(0, 3) == 0) octava = 2'($urandom);
      reset = ($urandom_range(0, 39) == 0);
      n = reset ? $urandom_range(1, 3) : $urandom_range(1, 25);
      for (int k = 0; k < n; k++) tick();
    end
    reset = 1'b0;
    applyStimulus(3'b000, 2'd0, 5);

    $display("[TB] reset mid-note, full-size table");
    teclas_b = 7'b0000001;
    waitActivoB(1'b1, 20, n);
    checkOutput("t6_press", 32'(n), 32'd7);
    for (int i = 0; i < 100; i++) tick();
    checkOutput("t6_high", 32'(clk_out_b), 32'd1);
    reset_b = 1'b1;
    tick();
    checkOutput("t6_rst_clk", 32'(clk_out_b), 32'd0);
    checkOutput("t6_rst_activo", 32'(activo_b), 32'd0);
    checkOutput("t6_rst_nota", 32'(nota_b), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    reset_b = 1'b0;
    waitActivoB(1'b1, 20, n);
    checkOutput("t6_restart", 32'(n), 32'd7);
    measureHalf(1, 30000, n);
    checkOutput("t6_half", 32'(n), 32'd23901);
    checkOutput("t6_nota", 32'(nota_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
